// File: rtl/vread_pkg.sv
// Shared types and constants for the vector pair reader.
// Optional build macro: VREAD_STRIDE_EN (adds a word-stride input).
package vread_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  // Turn a word index into a byte address (32-bit modulo).
  function automatic logic [31:0] word_addr(
    input logic [31-ADDR_LSB:0] w
  );
    return 32'(w) * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/vread_out_stage.sv
// Single-entry valid/ready output register for the pair stream.
// Loads a new pair on load; empties when the consumer accepts.
module vread_out_stage
  import vread_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last
);

  logic accept;

  assign accept = out_valid && out_ready;

  // Pair register: load wins, otherwise drop valid on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_a     <= in_a;
      out_b     <= in_b;
      out_last  <= in_last;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_pair_reader.sv
// Walks two vectors in lock-step and streams the element pairs.
// Optional build macro: VREAD_STRIDE_EN (adds an 8-bit word stride).
module vec_pair_reader
  import vread_pkg::*;
#(
  parameter int LEN_W  = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_a,
  input  logic [31:0]       base_b,
  input  logic [LEN_W-1:0]  len,
`ifdef VREAD_STRIDE_EN
  input  logic [7:0]        stride,
`endif
  output logic [31:0]       addr_a,
  output logic [31:0]       addr_b,
  input  logic [DATA_W-1:0] rv_a,
  input  logic [DATA_W-1:0] rv_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int WA_W = 32 - ADDR_LSB;

  state_t           state_q;
  state_t           state_d;
  logic [WA_W-1:0]  abase_q;
  logic [WA_W-1:0]  bbase_q;
  logic [WA_W-1:0]  off_q;
  logic [WA_W-1:0]  step;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic             is_last;
  logic             load;
  logic             accept;
  logic             take;
  logic             unused_lsbs;

  assign unused_lsbs = ^{base_a[ADDR_LSB-1:0], base_b[ADDR_LSB-1:0]};

`ifdef VREAD_STRIDE_EN
  logic [7:0] stride_q;
  assign step = WA_W'(stride_q);
`else
  assign step = WA_W'(1);
`endif

  assign take    = (state_q == IDLE) && start;
  assign accept  = out_valid && out_ready;
  assign is_last = idx_q == (len_q - LEN_W'(1));
  assign addr_a  = word_addr(abase_q + off_q);
  assign addr_b  = word_addr(bbase_q + off_q);
  assign busy    = state_q != IDLE;
  assign done    = state_q == FIN;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and the output-stage load strobe.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        load = !out_valid || out_ready;
        if (load && is_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transfer context: bases and length latched at start, walk on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      abase_q <= '0;
      bbase_q <= '0;
      off_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else if (take) begin
      abase_q <= base_a[31:ADDR_LSB];
      bbase_q <= base_b[31:ADDR_LSB];
      off_q   <= '0;
      len_q   <= len;
      idx_q   <= '0;
    end else if (load) begin
      off_q   <= off_q + step;
      idx_q   <= idx_q + LEN_W'(1);
    end
  end

`ifdef VREAD_STRIDE_EN
  // Stride is fixed for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst)       stride_q <= 8'd1;
    else if (take) stride_q <= stride;
  end
`endif

  vread_out_stage #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .in_a      (rv_a),
    .in_b      (rv_b),
    .in_last   (is_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_vec_pair_reader.sv
// Directed bench for vec_pair_reader with a queue-based pair model.
// Build with +define+VREAD_STRIDE_EN to cover the stride option.
module tb_vec_pair_reader;

  localparam int LEN_W  = 11;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
  } pair_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       base_a = '0;
  logic [31:0]       base_b = '0;
  logic [LEN_W-1:0]  len = '0;
`ifdef VREAD_STRIDE_EN
  logic [7:0]        stride_v = 8'd1;
`endif
  logic [31:0]       addr_a;
  logic [31:0]       addr_b;
  logic [DATA_W-1:0] rv_a;
  logic [DATA_W-1:0] rv_b;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [31:0] mem_w [0:1023];
  pair_t       exp_q [$];
  pair_t       mon_e;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        prv_v = 1'b0;
  logic        prv_r = 1'b0;
  logic [DATA_W-1:0] prv_a = '0;
  logic [DATA_W-1:0] prv_b = '0;
  logic        prv_l = 1'b0;

  always #5 clk = ~clk;

  assign rv_a = mem_w[addr_a[11:2]];
  assign rv_b = mem_w[addr_b[11:2]];

  vec_pair_reader #(
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_a    (base_a),
    .base_b    (base_b),
    .len       (len),
`ifdef VREAD_STRIDE_EN
    .stride    (stride_v),
`endif
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .rv_a      (rv_a),
    .rv_b      (rv_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: pair i comes from word (base>>2)+i*stride of each vector.
  task automatic expect_run(input logic [31:0] ba, input logic [31:0] bb,
                            input int n, input int st);
    pair_t e;
    logic [31:0] wa;
    logic [31:0] wb;
    for (int i = 0; i < n; i++) begin
      wa = (ba >> 2) + 32'(i * st);
      wb = (bb >> 2) + 32'(i * st);
      e.a = mem_w[wa[9:0]];
      e.b = mem_w[wb[9:0]];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] ba, input logic [31:0] bb,
                       input int n, input int st);
    @(posedge clk);
    #1;
    base_a = ba;
    base_b = bb;
    len = LEN_W'(n);
`ifdef VREAD_STRIDE_EN
    stride_v = 8'(st);
`endif
    start = 1'b1;
    expect_run(ba, bb, n, st);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) seen = 1;
      n++;
    end
    chk(nm, 128'(seen), 128'(1));
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_valid"}, 128'(out_valid), 128'(0));
    chk({nm, "_a"}, 128'(out_a), 128'(0));
    chk({nm, "_b"}, 128'(out_b), 128'(0));
    chk({nm, "_last"}, 128'(out_last), 128'(0));
    chk({nm, "_busy"}, 128'(busy), 128'(0));
    chk({nm, "_done"}, 128'(done), 128'(0));
    chk({nm, "_addr_a"}, 128'(addr_a), 128'(0));
    chk({nm, "_addr_b"}, 128'(addr_b), 128'(0));
  endtask

  // Compare every visible pair against the model and check stall hold.
  always @(negedge clk) begin
    if (rst) begin
      prv_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prv_v && !prv_r) begin
        chk("stall_hold", {out_valid, out_a, out_b, out_last},
            {1'b1, prv_a, prv_b, prv_l});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_pair", 128'(out_valid), 128'(0));
        end else begin
          mon_e = exp_q[0];
          chk("model_pair", {out_a, out_b, out_last},
              {mon_e.a, mon_e.b, mon_e.last});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prv_v = out_valid;
      prv_r = out_ready;
      prv_a = out_a;
      prv_b = out_b;
      prv_l = out_last;
    end
  end

  initial begin
    int va [7];
    int aa [7];
    int la [7];
    int da [7];
    int ba [7];
    bit pat [4];
    int dc;
    va = '{0, 1, 1, 1, 1, 0, 0};
    aa = '{0, 1, 2, 3, 4, 0, 0};
    la = '{0, 0, 0, 0, 1, 0, 0};
    da = '{0, 0, 0, 0, 0, 1, 0};
    ba = '{1, 1, 1, 1, 1, 1, 0};
    pat = '{1, 0, 0, 1};

    for (int i = 0; i < 1024; i++) mem_w[i] = 32'hD000_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin
      mem_w[64 + i]  = 32'(i + 1);
      mem_w[128 + i] = 32'((i + 1) * 10);
    end
    mem_w[1023] = 32'h0000_AAAA;
    mem_w[0]    = 32'h0000_0B00;
    mem_w[3]    = 32'h0000_0B03;
    mem_w[6]    = 32'h0000_0B06;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outs("reset");

    // Basic stream, ready held high.
    issue(32'h100, 32'h200, 4, 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("basic_valid_%0d", k), 128'(out_valid), 128'(va[k]));
      if (va[k] != 0) begin
        chk($sformatf("basic_a_%0d", k), 128'(out_a), 128'(aa[k]));
        chk($sformatf("basic_b_%0d", k), 128'(out_b), 128'(aa[k] * 10));
      end
      chk($sformatf("basic_last_%0d", k), 128'(out_last & out_valid),
          128'(la[k]));
      chk($sformatf("basic_done_%0d", k), 128'(done), 128'(da[k]));
      chk($sformatf("basic_busy_%0d", k), 128'(busy), 128'(ba[k]));
      if (k == 0) chk("basic_addr_a0", 128'(addr_a), 128'(32'h100));
      if (k == 0) chk("basic_addr_b0", 128'(addr_b), 128'(32'h200));
      if (k == 1) chk("basic_addr_a1", 128'(addr_a), 128'(32'h104));
    end
    chk("basic_q_empty", 128'(exp_q.size()), 128'(0));

    // Backpressure with ready pattern 1,0,0,1.
    fork
      begin
        issue(32'h100, 32'h200, 4, 1);
        wait_done(60, "bp_done");
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(posedge clk);
          #1;
          out_ready = pat[c % 4];
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_q_empty", 128'(exp_q.size()), 128'(0));

    // Zero-length transfer.
    dc = done_cnt;
    issue(32'h100, 32'h200, 0, 1);
    @(negedge clk);
    chk("len0_busy0", 128'(busy), 128'(1));
    chk("len0_done0", 128'(done), 128'(1));
    @(negedge clk);
    chk("len0_busy1", 128'(busy), 128'(0));
    chk("len0_done1", 128'(done), 128'(0));
    repeat (3) @(negedge clk);
    chk("len0_done_once", 128'(done_cnt - dc), 128'(1));

    // Start while busy is ignored.
    issue(32'h100, 32'h200, 4, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    base_a = 32'h300;
    base_b = 32'h340;
    len = LEN_W'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20, "mid_done");
    repeat (4) @(negedge clk);
    chk("mid_idle", 128'(busy), 128'(0));
    chk("mid_q_empty", 128'(exp_q.size()), 128'(0));

    // Reset mid-transfer, then a single-element run.
    issue(32'h100, 32'h200, 4, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pair2_a", 128'(out_a), 128'(2));
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    dc = done_cnt;
    @(negedge clk);
    chk_idle_outs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - dc), 128'(0));
    issue(32'h108, 32'h208, 1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("len1_pair", {out_valid, out_a, out_b, out_last},
        {1'b1, 32'd3, 32'd30, 1'b1});
    wait_done(10, "len1_done");
    chk("len1_q_empty", 128'(exp_q.size()), 128'(0));

    // Address wrap past the top of memory.
    issue(32'hFFFF_FFFC, 32'h200, 2, 1);
    @(negedge clk);
    chk("wrap_addr0", 128'(addr_a), 128'(32'hFFFF_FFFC));
    @(negedge clk);
    chk("wrap_addr1", 128'(addr_a), 128'(32'h0));
    chk("wrap_a0", 128'(out_a), 128'(32'h0000_AAAA));
    wait_done(10, "wrap_done");
    chk("wrap_q_empty", 128'(exp_q.size()), 128'(0));

`ifdef VREAD_STRIDE_EN
    // Stride of three words from address zero.
    issue(32'h0, 32'h200, 3, 3);
    @(negedge clk);
    chk("stride_addr0", 128'(addr_a), 128'(32'h0));
    @(negedge clk);
    chk("stride_addr1", 128'(addr_a), 128'(32'hC));
    chk("stride_a0", 128'(out_a), 128'(32'h0000_0B00));
    @(negedge clk);
    chk("stride_addr2", 128'(addr_a), 128'(32'h18));
    chk("stride_b1", 128'(out_b), 128'(32'd40));
    wait_done(10, "stride_done");
    chk("stride_q_empty", 128'(exp_q.size()), 128'(0));
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
